// File: rtl/sb_io_pkg.sv
// Pin-type mode codes and the output-mode decoder shared by sb_io_cell.
package sb_io_pkg;

    localparam logic [5:0] PIN_TYPE_DEFAULT = 6'b101001;

    localparam logic [3:0] OUT_NONE        = 4'b0000;
    localparam logic [3:0] OUT_COMB        = 4'b0110;
    localparam logic [3:0] OUT_COMB_OE     = 4'b1010;
    localparam logic [3:0] OUT_COMB_REGOE  = 4'b1110;
    localparam logic [3:0] OUT_REG         = 4'b0101;
    localparam logic [3:0] OUT_REG_COMBOE  = 4'b1001;
    localparam logic [3:0] OUT_REG_REGOE   = 4'b1101;

    localparam logic [1:0] IN_REG  = 2'b00;
    localparam logic [1:0] IN_COMB = 2'b01;

    typedef enum logic [1:0] {
        EN_NEVER,
        EN_ALWAYS,
        EN_COMB,
        EN_REG
    } out_en_e;

    typedef struct packed {
        logic    data_reg;
        out_en_e en;
    } out_cfg_t;

    // Unknown output codes fall back to never-drive.
    function automatic out_cfg_t out_decode(input logic [3:0] code);
        out_cfg_t cfg;
        case (code)
            OUT_COMB:       cfg = '{1'b0, EN_ALWAYS};
            OUT_COMB_OE:    cfg = '{1'b0, EN_COMB};
            OUT_COMB_REGOE: cfg = '{1'b0, EN_REG};
            OUT_REG:        cfg = '{1'b1, EN_ALWAYS};
            OUT_REG_COMBOE: cfg = '{1'b1, EN_COMB};
            OUT_REG_REGOE:  cfg = '{1'b1, EN_REG};
            default:        cfg = '{1'b0, EN_NEVER};
        endcase
        return cfg;
    endfunction

endpackage

// File: rtl/sb_io_cell.sv
// Bidirectional pad cell with selectable registered/combinational
// output data, output enable and input capture.
module sb_io_cell
    import sb_io_pkg::*;
#(
    parameter logic [5:0] PIN_TYPE = PIN_TYPE_DEFAULT,
    parameter logic       PULLUP   = 1'b0
) (
    input  logic clk48,
    input  logic rst,
    input  logic CLOCK_ENABLE,
    input  logic OUTPUT_ENABLE,
    input  logic D_OUT_0,
    output logic D_IN_0,
    inout  wire  PACKAGE_PIN
);

    localparam out_cfg_t OCFG    = out_decode(PIN_TYPE[5:2]);
    localparam logic     IN_REGD = (PIN_TYPE[1:0] == IN_REG);

    logic dout_q;
    logic oe_q;
    logic din_q;
    logic pad_en;
    logic pad_val;

    generate
        if (OCFG.data_reg) begin : g_dout_reg
            logic dout_d;
            always_comb dout_d = CLOCK_ENABLE ? D_OUT_0 : dout_q;
            always_ff @(posedge clk48) begin
                if (rst) dout_q <= 1'b0;
                else     dout_q <= dout_d;
            end
        end else begin : g_dout_comb
            assign dout_q = 1'b0;
        end

        if (OCFG.en == EN_REG) begin : g_oe_reg
            logic oe_d;
            always_comb oe_d = CLOCK_ENABLE ? OUTPUT_ENABLE : oe_q;
            always_ff @(posedge clk48) begin
                if (rst) oe_q <= 1'b0;
                else     oe_q <= oe_d;
            end
        end else begin : g_oe_comb
            assign oe_q = 1'b0;
        end

        if (IN_REGD) begin : g_din_reg
            logic din_d;
            always_comb din_d = CLOCK_ENABLE ? PACKAGE_PIN : din_q;
            always_ff @(posedge clk48) begin
                if (rst) din_q <= 1'b0;
                else     din_q <= din_d;
            end
        end else begin : g_din_comb
            assign din_q = 1'b0;
        end

        if (PULLUP) begin : g_pullup
            pullup (PACKAGE_PIN);
        end
    endgenerate

    // Enable and data resolve in one block so they switch together.
    always_comb begin
        pad_val = OCFG.data_reg ? dout_q : D_OUT_0;
        unique case (OCFG.en)
            EN_ALWAYS: pad_en = 1'b1;
            EN_COMB:   pad_en = OUTPUT_ENABLE;
            EN_REG:    pad_en = oe_q;
            default:   pad_en = 1'b0;
        endcase
    end

    assign PACKAGE_PIN = pad_en ? pad_val : 1'bz;
    assign D_IN_0      = IN_REGD ? din_q : PACKAGE_PIN;

    logic unused_ok;
    assign unused_ok = ^{clk48, rst, CLOCK_ENABLE};

endmodule

// File: tb/tb_sb_io_cell.sv
// Self-checking bench for sb_io_cell across all pin modes.
module tb_sb_io_cell;

    localparam int NI = 8;
    localparam logic [5:0] PT [NI] = '{
        6'b101001, 6'b010100, 6'b110101, 6'b111001,
        6'b100100, 6'b011001, 6'b001101, 6'b101001
    };
    localparam logic [NI-1:0] PULLV = 8'b1000_0000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, ce, oe, dout;
    logic [NI-1:0] ext_en, ext_val, din;
    wire p0, p1, p2, p3, p4, p5, p6, p7;
    wire [NI-1:0] pad;

    assign pad = {p7, p6, p5, p4, p3, p2, p1, p0};
    assign p0 = ext_en[0] ? ext_val[0] : 1'bz;
    assign p1 = ext_en[1] ? ext_val[1] : 1'bz;
    assign p2 = ext_en[2] ? ext_val[2] : 1'bz;
    assign p3 = ext_en[3] ? ext_val[3] : 1'bz;
    assign p4 = ext_en[4] ? ext_val[4] : 1'bz;
    assign p5 = ext_en[5] ? ext_val[5] : 1'bz;
    assign p6 = ext_en[6] ? ext_val[6] : 1'bz;
    assign p7 = ext_en[7] ? ext_val[7] : 1'bz;

    sb_io_cell #(.PIN_TYPE(PT[0]), .PULLUP(1'b0)) u_c (
        .clk48(clk), .rst(rst), .CLOCK_ENABLE(ce), .OUTPUT_ENABLE(oe),
        .D_OUT_0(dout), .D_IN_0(din[0]), .PACKAGE_PIN(p0));
    sb_io_cell #(.PIN_TYPE(PT[1]), .PULLUP(1'b0)) u_rd (
        .clk48(clk), .rst(rst), .CLOCK_ENABLE(ce), .OUTPUT_ENABLE(oe),
        .D_OUT_0(dout), .D_IN_0(din[1]), .PACKAGE_PIN(p1));
    sb_io_cell #(.PIN_TYPE(PT[2]), .PULLUP(1'b0)) u_rr (
        .clk48(clk), .rst(rst), .CLOCK_ENABLE(ce), .OUTPUT_ENABLE(oe),
        .D_OUT_0(dout), .D_IN_0(din[2]), .PACKAGE_PIN(p2));
    sb_io_cell #(.PIN_TYPE(PT[3]), .PULLUP(1'b0)) u_ce (
        .clk48(clk), .rst(rst), .CLOCK_ENABLE(ce), .OUTPUT_ENABLE(oe),
        .D_OUT_0(dout), .D_IN_0(din[3]), .PACKAGE_PIN(p3));
    sb_io_cell #(.PIN_TYPE(PT[4]), .PULLUP(1'b0)) u_rc (
        .clk48(clk), .rst(rst), .CLOCK_ENABLE(ce), .OUTPUT_ENABLE(oe),
        .D_OUT_0(dout), .D_IN_0(din[4]), .PACKAGE_PIN(p4));
    sb_io_cell #(.PIN_TYPE(PT[5]), .PULLUP(1'b0)) u_ao (
        .clk48(clk), .rst(rst), .CLOCK_ENABLE(ce), .OUTPUT_ENABLE(oe),
        .D_OUT_0(dout), .D_IN_0(din[5]), .PACKAGE_PIN(p5));
    sb_io_cell #(.PIN_TYPE(PT[6]), .PULLUP(1'b0)) u_bad (
        .clk48(clk), .rst(rst), .CLOCK_ENABLE(ce), .OUTPUT_ENABLE(oe),
        .D_OUT_0(dout), .D_IN_0(din[6]), .PACKAGE_PIN(p6));
    sb_io_cell #(.PIN_TYPE(PT[7]), .PULLUP(1'b1)) u_pu (
        .clk48(clk), .rst(rst), .CLOCK_ENABLE(ce), .OUTPUT_ENABLE(oe),
        .D_OUT_0(dout), .D_IN_0(din[7]), .PACKAGE_PIN(p7));

    int errors = 0;
    int checks = 0;

    // Reference model: last values sampled on an enabled edge.
    logic m_dq [NI];
    logic m_eq [NI];
    logic m_iq [NI];

    function automatic void predict(input int i, output logic en,
                                    output logic val);
        logic [3:0] oc;
        oc  = PT[i][5:2];
        en  = 1'b0;
        val = 1'b0;
        case (oc)
            4'b0110: begin en = 1'b1;    val = dout;    end
            4'b1010: begin en = oe;      val = dout;    end
            4'b1110: begin en = m_eq[i]; val = dout;    end
            4'b0101: begin en = 1'b1;    val = m_dq[i]; end
            4'b1001: begin en = oe;      val = m_dq[i]; end
            4'b1101: begin en = m_eq[i]; val = m_dq[i]; end
            default: begin en = 1'b0;    val = 1'b0;    end
        endcase
    endfunction

    function automatic logic pad_model(input int i);
        logic en, val;
        predict(i, en, val);
        if (en)             return val;
        else if (ext_en[i]) return ext_val[i];
        else if (PULLV[i])  return 1'b1;
        else                return 1'bx;
    endfunction

    function automatic logic din_model(input int i);
        if (PT[i][1:0] == 2'b00) return m_iq[i];
        else                     return pad_model(i);
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < NI; i++) begin
            logic p;
            p = pad_model(i);
            if (rst) begin
                m_dq[i] <= 1'b0;
                m_eq[i] <= 1'b0;
                m_iq[i] <= 1'b0;
            end else if (ce) begin
                m_dq[i] <= dout;
                m_eq[i] <= oe;
                m_iq[i] <= p;
            end
        end
    end

    task automatic chk(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b want %b", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    typedef struct {
        logic r, o, d, xen, xval, epad, edin;
    } vec_t;
    vec_t tbl [8];

    initial begin
        rst = 1'b1; ce = 1'b0; oe = 1'b1; dout = 1'b1;
        ext_en = '0; ext_val = '0;
        ext_en[3] = 1'b1;
        tick();
        tick();
        #1;
        chk("rst regoe undriven", p3, 1'b0);
        chk("rst regdata pad", p1, 1'b0);
        chk("rst regin din", din[1], 1'b0);
        chk("rst regdata combOE pad", p4, 1'b0);
        chk("rst regin din4", din[4], 1'b0);
        ext_en = '0;
        rst = 1'b0;
        ce = 1'b1;

        tbl[0] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        tbl[2] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        tbl[3] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[4] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        tbl[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        tbl[6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        tbl[7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        for (int k = 0; k < 8; k++) begin
            rst = tbl[k].r; oe = tbl[k].o; dout = tbl[k].d;
            ext_en[0] = tbl[k].xen; ext_val[0] = tbl[k].xval;
            #1;
            chk($sformatf("tbl%0d pad", k), p0, tbl[k].epad);
            chk($sformatf("tbl%0d din", k), din[0], tbl[k].edin);
            tick();
        end
        rst = 1'b0; ext_en = '0; ext_val = '0;

        // Registered data, registered input latency.
        oe = 1'b1; dout = 1'b0; ce = 1'b1;
        tick();
        tick();
        #1;
        chk("rd pre pad", p1, 1'b0);
        chk("rd pre din", din[1], 1'b0);
        dout = 1'b1;
        #1;
        chk("rd same cycle pad", p1, 1'b0);
        tick();
        #1;
        chk("rd +1 pad", p1, 1'b1);
        chk("rd +1 din", din[1], 1'b0);
        tick();
        #1;
        chk("rd +2 din", din[1], 1'b1);

        // Registered enable held off while clock enable is low.
        oe = 1'b0;
        tick();
        ce = 1'b0; oe = 1'b1; dout = 1'b1;
        ext_en[2] = 1'b1; ext_val[2] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("ce0 hold%0d", k), p2, 1'b0);
            tick();
        end
        ce = 1'b1;
        #1;
        chk("ce1 pre edge", p2, 1'b0);
        tick();
        ext_en[2] = 1'b0;
        #1;
        chk("ce1 driven", p2, 1'b1);

        // Reset with clock enable low clears registers.
        ce = 1'b0; rst = 1'b1;
        ext_en[3] = 1'b1; ext_val[3] = 1'b0;
        tick();
        #1;
        chk("rst ce0 undriven", p3, 1'b0);
        chk("rst ce0 dq", p1, 1'b0);
        chk("rst ce0 din", din[1], 1'b0);
        rst = 1'b0;
        tick();
        #1;
        chk("post rst hold", p3, 1'b0);
        chk("post rst hold dq", p1, 1'b0);
        ce = 1'b1;
        tick();
        ext_en[3] = 1'b0;
        #1;
        chk("resume oe", p3, 1'b1);
        chk("resume dq", p1, 1'b1);

        // Unsupported output code never drives.
        oe = 1'b1; dout = 1'b1;
        ext_en[6] = 1'b1; ext_val[6] = 1'b0;
        #1;
        chk("bad pad", p6, 1'b0);
        chk("bad din", din[6], 1'b0);
        tick();
        #1;
        chk("bad pad2", p6, 1'b0);
        ext_val[6] = 1'b1;
        #1;
        chk("bad din ext1", din[6], 1'b1);
        ext_en = '0;

        // Pull-up resolves an undriven pad high.
        oe = 1'b0; dout = 1'b0;
        #1;
        chk("pu din", din[7], 1'b1);
        chk("pu pad", p7, 1'b1);
        oe = 1'b1;
        #1;
        chk("pu driven0", p7, 1'b0);
        chk("pu driven0 din", din[7], 1'b0);

        // Randomised run against the model.
        rst = 1'b1; ce = 1'b0;
        tick();
        rst = 1'b0;
        for (int c = 0; c < 400; c++) begin
            rst  = ($urandom_range(0, 19) == 0);
            ce   = ($urandom_range(0, 3) != 0);
            oe   = 1'($urandom_range(0, 1));
            dout = 1'($urandom_range(0, 1));
            for (int i = 0; i < NI; i++) begin
                logic en, val;
                predict(i, en, val);
                if (en)          ext_en[i] = 1'b0;
                else if (i == 7) ext_en[i] = 1'($urandom_range(0, 1));
                else             ext_en[i] = 1'b1;
                ext_val[i] = 1'($urandom_range(0, 1));
            end
            #1;
            for (int i = 0; i < NI; i++) begin
                chk($sformatf("rnd%0d pad%0d", c, i), pad[i], pad_model(i));
                chk($sformatf("rnd%0d din%0d", c, i), din[i], din_model(i));
            end
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sb_io_cell.md
SB_IO_CELL -- requirements
Module: sb_io_cell

Interface
REQ-001 Parameter PIN_TYPE, default 6'b101001, selects the pin mode: bits [5:2] set the output mode and bits [1:0] set the input mode.
REQ-002 Parameter PULLUP, default 1'b0; 1 means the pin resolves weak-high when it is not driven.
REQ-003 Port clk48, input, 1 bit: the single clock for every register in the cell.
REQ-004 Port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 Port CLOCK_ENABLE, input, 1 bit: gates every I/O register; tie to 1 when unused.
REQ-006 Port OUTPUT_ENABLE, input, 1 bit: requests that the pad be driven.
REQ-007 Port D_OUT_0, input, 1 bit: data to drive onto the pad.
REQ-008 Port D_IN_0, output, 1 bit: data sampled from the pad.
REQ-009 Port PACKAGE_PIN, inout, 1 bit: the bidirectional pad.

Function
REQ-010 Output modes (PIN_TYPE[5:2]) SHALL be decoded as follows:
- 0000: never drive.
- 0110: always drive D_OUT_0 combinationally.
- 1010: drive D_OUT_0 combinationally while OUTPUT_ENABLE=1.
- 1110: combinational data, registered enable.
- 0101: registered data, always enabled.
- 1001: registered data, combinational enable.
- 1101: registered data and registered enable.
REQ-011 Any other output-mode code SHALL behave as 0000 (never drive).
REQ-012 When the pad is not driven, PACKAGE_PIN SHALL be 'z'; with PULLUP=1 it SHALL be weak '1' ('z' pulled up).
REQ-013 Input modes (PIN_TYPE[1:0]) SHALL be decoded as follows:
- 01: D_IN_0 = PACKAGE_PIN combinationally (zero latency).
- 00: D_IN_0 = PACKAGE_PIN registered on the rising edge of clk48 (1-cycle latency).
- 10 and 11: treated as 01.
REQ-014 A registered stage SHALL capture only in cycles where CLOCK_ENABLE=1 and SHALL hold its value otherwise.
REQ-015 In registered output modes, D_OUT_0 and/or OUTPUT_ENABLE SHALL appear on the pad exactly 1 cycle after being sampled.
REQ-016 D_IN_0 SHALL always reflect the pad value, including the cell's own driven value (loopback), so the consumer masks echo using OUTPUT_ENABLE.
REQ-017 If the pad is externally 'x' or 'z' without pull-up, D_IN_0 SHALL pass 'x' or 'z' in simulation; synthesis treats this as don't-care.
REQ-018 A simultaneous change of OUTPUT_ENABLE and D_OUT_0 in combinational mode SHALL take effect in the same delta, with no glitch to a stale value.

Reset
REQ-019 While rst=1 on a clk48 edge, the registered data, registered enable and registered input SHALL all clear to 0, regardless of CLOCK_ENABLE.
REQ-020 Under reset, modes with a registered enable SHALL leave the pad undriven.
REQ-021 Reset SHALL NOT affect combinational paths.
REQ-022 Deasserting reset mid-operation SHALL resume normal capture on the next enabled edge.

Structure
REQ-023 Pin-type mode constants (output mode codes, input mode codes, default 6'b101001) SHALL live in the shared package sb_io_pkg.
REQ-024 The cell SHALL be a single flat module with no sub-module; output and input paths are separate always blocks selected by generate on PIN_TYPE.

Verification
REQ-025 PIN_TYPE=101001, OUTPUT_ENABLE=1, D_OUT_0=0 -> PACKAGE_PIN=0 and D_IN_0=0 immediately; OUTPUT_ENABLE=0 with external drive 1 -> PACKAGE_PIN=z from the cell, D_IN_0=1.
REQ-026 PIN_TYPE=010100, D_OUT_0 toggles 0->1 at edge N -> pad=1 after edge N+1 sample point; D_IN_0 registered shows 1 one cycle after the pad.
REQ-027 PIN_TYPE=110101, OUTPUT_ENABLE=1 and CLOCK_ENABLE=0 for 3 cycles -> pad stays z; CLOCK_ENABLE=1 -> pad driven after 1 cycle.
REQ-028 Registered modes, assert rst for 1 cycle while CLOCK_ENABLE=0 -> registers read 0 on the next cycle and the pad is undriven.
REQ-029 PULLUP=1, OUTPUT_ENABLE=0, no external driver -> D_IN_0=1.
REQ-030 PIN_TYPE output code 0011 (unsupported), OUTPUT_ENABLE=1 -> pad never driven.
